// File: rtl/ser_lane_pkg.sv
// Shared types and constants for the serializer lane controller:
// FSM state encoding, default lane words and the PRBS7 chunk generator.
package ser_lane_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        TRAIN = 2'd1,
        LINK  = 2'd2
    } lane_state_t;

    localparam logic [9:0] DEF_TRAIN_WORD = 10'h155;
    localparam logic [9:0] DEF_IDLE_WORD  = 10'h354;
    localparam logic [9:0] DEF_SYNC_WORD  = 10'h0AB;

    localparam logic [6:0] PRBS7_SEED = 7'h7F;

    typedef struct packed {
        logic [6:0] state;
        logic [9:0] word;
    } prbs_step_t;

    // Advance a PRBS7 (x^7 + x^6 + 1) LFSR by ten bits. The first bit produced
    // lands in word[9], so the chunk reads MSB-first in time.
    function automatic prbs_step_t prbs7_step10(input logic [6:0] state);
        prbs_step_t r;
        logic [6:0] s;
        logic       fb;
        s      = state;
        r.word = '0;
        for (int i = 9; i >= 0; i--) begin
            fb        = s[6] ^ s[5];
            s         = {s[5:0], fb};
            r.word[i] = fb;
        end
        r.state = s;
        return r;
    endfunction

endpackage

// File: rtl/ser_lane_prbs7.sv
// Ten-bits-per-cycle PRBS7 training pattern source. load_i restarts the
// sequence from the seed and emits its first chunk in the same cycle;
// adv_i emits the following chunk. Only built with SER_LANE_CTRL_PRBS_TRAIN_EN.
module ser_lane_prbs7
    import ser_lane_pkg::*;
(
    input  logic       ref_clk_i,
    input  logic       rst,
    input  logic       load_i,
    input  logic       adv_i,
    output logic [9:0] word_o
);

    logic [6:0] lfsr_q;
    logic [6:0] lfsr_d;
    prbs_step_t step;

    // Chunk for this cycle, taken from the seed on load or the live LFSR otherwise.
    // NOTE: every variable gets a value on every path, so no latch is inferred.
    always_comb begin
        step   = prbs7_step10(load_i ? PRBS7_SEED : lfsr_q);
        word_o = step.word;
        lfsr_d = step.state;
    end

    // LFSR state only moves when a chunk is actually consumed.
    always_ff @(posedge ref_clk_i) begin
        if (rst) begin
            lfsr_q <= PRBS7_SEED;
        end else if (load_i || adv_i) begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/serializer_lane_ctrl.sv
// Sequencing controller for one 10:1 DDR serializer lane (word-clock domain).
// HOLD keeps the serializer in reset until the PLL has been locked for
// LOCK_CYCLES, TRAIN sends TRAIN_LEN preamble words, LINK streams user data
// with idle fill and a sync word in the last slot of every SYNC_PERIOD.
// Build option: define SER_LANE_CTRL_PRBS_TRAIN_EN for a PRBS7 preamble
// instead of the constant TRAIN_WORD.
module serializer_lane_ctrl
    import ser_lane_pkg::*;
#(
    parameter int unsigned LOCK_CYCLES = 16,
    parameter int unsigned TRAIN_LEN   = 64,
    parameter int unsigned SYNC_PERIOD = 1024,
    parameter logic [9:0]  TRAIN_WORD  = DEF_TRAIN_WORD,
    parameter logic [9:0]  IDLE_WORD   = DEF_IDLE_WORD,
    parameter logic [9:0]  SYNC_WORD   = DEF_SYNC_WORD
) (
    input  logic       ref_clk_i,
    input  logic       rst,
    input  logic       pll_locked_i,
    input  logic       s_valid_i,
    input  logic [9:0] s_dat_i,
    output logic       s_ready_o,
    output logic       ser_rst_o,
    output logic [9:0] ser_dat_o,
    output logic       link_up_o,
    output logic       sync_o
);

    localparam int LOCK_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int TRAIN_W = (TRAIN_LEN   > 1) ? $clog2(TRAIN_LEN)   : 1;
    localparam int SLOT_W  = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;

    localparam logic [LOCK_W-1:0]  LOCK_LAST  = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [TRAIN_W-1:0] TRAIN_LAST = TRAIN_W'(TRAIN_LEN - 1);
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SYNC_PERIOD - 1);
    localparam logic [SLOT_W-1:0]  SLOT_PRE   = SLOT_W'(SYNC_PERIOD - 2);

    lane_state_t        state_q;
    logic [LOCK_W-1:0]  lock_cnt_q;
    logic [TRAIN_W-1:0] train_cnt_q;
    logic [SLOT_W-1:0]  slot_cnt_q;
    logic               ser_rst_q;
    logic [9:0]         ser_dat_q;
    logic               s_ready_q;
    logic               link_up_q;
    logic               sync_q;
    logic [9:0]         train_word;

`ifdef SER_LANE_CTRL_PRBS_TRAIN_EN
    logic hold_exit;
    logic train_adv;

    // Tell the generator when the first and each following preamble word is taken.
    always_comb begin
        hold_exit = !rst && pll_locked_i && (state_q == HOLD)
                    && (lock_cnt_q == LOCK_LAST);
        train_adv = !rst && pll_locked_i && (state_q == TRAIN)
                    && (train_cnt_q != TRAIN_LAST);
    end

    ser_lane_prbs7 u_prbs7 (
        .ref_clk_i (ref_clk_i),
        .rst       (rst),
        .load_i    (hold_exit),
        .adv_i     (train_adv),
        .word_o    (train_word)
    );
`else
    assign train_word = TRAIN_WORD;
`endif

    // Lane FSM with registered outputs; outputs are loaded together with the
    // state they belong to. Losing PLL lock is treated exactly like reset.
    // NOTE: non-blocking (<=) on every register so all updates use pre-edge values.
    always_ff @(posedge ref_clk_i) begin
        if (rst || !pll_locked_i) begin
            state_q     <= HOLD;
            lock_cnt_q  <= '0;
            train_cnt_q <= '0;
            slot_cnt_q  <= '0;
            ser_rst_q   <= 1'b1;
            ser_dat_q   <= IDLE_WORD;
            s_ready_q   <= 1'b0;
            link_up_q   <= 1'b0;
            sync_q      <= 1'b0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (lock_cnt_q == LOCK_LAST) begin
                        state_q    <= TRAIN;
                        lock_cnt_q <= '0;
                        ser_rst_q  <= 1'b0;
                        ser_dat_q  <= train_word;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + LOCK_W'(1);
                    end
                end
                TRAIN: begin
                    if (train_cnt_q == TRAIN_LAST) begin
                        // First LINK cycle carries fill: nothing was offered yet.
                        state_q     <= LINK;
                        train_cnt_q <= '0;
                        slot_cnt_q  <= '0;
                        ser_dat_q   <= IDLE_WORD;
                        link_up_q   <= 1'b1;
                        s_ready_q   <= 1'b1;
                    end else begin
                        train_cnt_q <= train_cnt_q + TRAIN_W'(1);
                        ser_dat_q   <= train_word;
                    end
                end
                LINK: begin
                    if (slot_cnt_q == SLOT_LAST) begin
                        slot_cnt_q <= '0;
                        ser_dat_q  <= SYNC_WORD;
                        sync_q     <= 1'b1;
                        s_ready_q  <= 1'b1;
                    end else begin
                        slot_cnt_q <= slot_cnt_q + SLOT_W'(1);
                        ser_dat_q  <= (s_valid_i && s_ready_q) ? s_dat_i : IDLE_WORD;
                        sync_q     <= 1'b0;
                        // Drop ready ahead of the sync slot so upstream never
                        // sees a combinational valid-to-ready path.
                        s_ready_q  <= (slot_cnt_q != SLOT_PRE);
                    end
                end
                default: begin
                    state_q <= HOLD;
                end
            endcase
        end
    end

    assign s_ready_o = s_ready_q;
    assign ser_rst_o = ser_rst_q;
    assign ser_dat_o = ser_dat_q;
    assign link_up_o = link_up_q;
    assign sync_o    = sync_q;

endmodule

// File: tb/tb_serializer_lane_ctrl.sv
// Self-checking bench for serializer_lane_ctrl: reset, lock glitch, training,
// link streaming with sync slots, lock loss mid-link and mid-operation reset.
// Expected words go into a scoreboard queue as stimulus is applied and are
// compared against the DUT outputs one cycle later.
module tb_serializer_lane_ctrl;

    localparam int LOCK_CYCLES = 16;
    localparam int TRAIN_LEN   = 64;
    localparam int SYNC_PERIOD = 8;

    localparam logic [9:0] TRAIN_W = 10'h155;
    localparam logic [9:0] IDLE_W  = 10'h354;
    localparam logic [9:0] SYNC_W  = 10'h0AB;

    logic       ref_clk_i = 1'b0;
    logic       rst;
    logic       pll_locked_i;
    logic       s_valid_i;
    logic [9:0] s_dat_i;
    logic       s_ready_o;
    logic       ser_rst_o;
    logic [9:0] ser_dat_o;
    logic       link_up_o;
    logic       sync_o;

    typedef struct packed {
        logic       rst;
        logic [9:0] dat;
        logic       link;
        logic       sync;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         slot     = 0;
    logic [9:0] next_dat = 10'h001;
    logic [6:0] ref_lfsr = 7'h7F;

    serializer_lane_ctrl #(
        .LOCK_CYCLES (LOCK_CYCLES),
        .TRAIN_LEN   (TRAIN_LEN),
        .SYNC_PERIOD (SYNC_PERIOD)
    ) dut (
        .ref_clk_i    (ref_clk_i),
        .rst          (rst),
        .pll_locked_i (pll_locked_i),
        .s_valid_i    (s_valid_i),
        .s_dat_i      (s_dat_i),
        .s_ready_o    (s_ready_o),
        .ser_rst_o    (ser_rst_o),
        .ser_dat_o    (ser_dat_o),
        .link_up_o    (link_up_o),
        .sync_o       (sync_o)
    );

    always #5 ref_clk_i = ~ref_clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge ref_clk_i);
        #1;
    endtask

    task automatic push_exp(input logic r, input logic [9:0] d, input logic l, input logic s);
        exp_t e;
        e.rst  = r;
        e.dat  = d;
        e.link = l;
        e.sync = s;
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        e = sb_q.pop_front();
        check({tag, ".ser_rst"}, 32'(ser_rst_o), 32'(e.rst));
        check({tag, ".ser_dat"}, 32'(ser_dat_o), 32'(e.dat));
        check({tag, ".link_up"}, 32'(link_up_o), 32'(e.link));
        check({tag, ".sync"},    32'(sync_o),    32'(e.sync));
    endtask

    // Reference preamble word: bit-serial PRBS7 model or the constant word.
    function automatic logic [9:0] train_exp();
`ifdef SER_LANE_CTRL_PRBS_TRAIN_EN
        logic [9:0] w;
        logic       fb;
        w = '0;
        for (int i = 0; i < 10; i++) begin
            fb       = ref_lfsr[6] ^ ref_lfsr[5];
            ref_lfsr = {ref_lfsr[5:0], fb};
            w        = {w[8:0], fb};
        end
        return w;
`else
        return TRAIN_W;
`endif
    endfunction

    // From a HOLD cycle with lock asserted: measure reset hold, check the
    // whole preamble, then the LINK entry word.
    task automatic bringup();
        int n;
        n = 0;
        while (ser_rst_o === 1'b1 && n < 200) begin
            n++;
            step();
        end
        check("rst_hold_cycles", 32'(n), 32'(LOCK_CYCLES));
        ref_lfsr = 7'h7F;
        for (int i = 0; i < TRAIN_LEN; i++) push_exp(1'b0, train_exp(), 1'b0, 1'b0);
        while (sb_q.size() > 0) begin
            pop_cmp("train");
            step();
        end
        push_exp(1'b0, IDLE_W, 1'b1, 1'b0);
        pop_cmp("link_entry");
        slot = 0;
    endtask

    // One LINK slot: check ready, offer (or not) the next data word, predict output.
    task automatic link_cycle(input logic valid);
        logic is_sync;
        is_sync = (slot == SYNC_PERIOD - 1);
        check("s_ready", 32'(s_ready_o), 32'(!is_sync));
        s_valid_i = valid;
        s_dat_i   = next_dat;
        if (is_sync) begin
            push_exp(1'b0, SYNC_W, 1'b1, 1'b1);
        end else if (valid) begin
            push_exp(1'b0, next_dat, 1'b1, 1'b0);
            next_dat = next_dat + 10'd1;
        end else begin
            push_exp(1'b0, IDLE_W, 1'b1, 1'b0);
        end
        step();
        pop_cmp(is_sync ? "sync_slot" : "data_slot");
        slot = (slot + 1) % SYNC_PERIOD;
    endtask

    initial begin
        rst          = 1'b1;
        pll_locked_i = 1'b1;
        s_valid_i    = 1'b0;
        s_dat_i      = '0;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            step();
            push_exp(1'b1, IDLE_W, 1'b0, 1'b0);
            pop_cmp("reset");
            check("reset.s_ready", 32'(s_ready_o), 32'd0);
        end
        rst = 1'b0;

        // Lock glitch at lock_cnt = 10: count must restart from zero.
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold.ser_rst", 32'(ser_rst_o), 32'd1);
        end
        pll_locked_i = 1'b0;
        step();
        check("glitch.ser_rst", 32'(ser_rst_o), 32'd1);
        pll_locked_i = 1'b1;
        bringup();

        // Continuous data, then no data.
        repeat (24) link_cycle(1'b1);
        repeat (16) link_cycle(1'b0);

        // Lock loss while a word is offered on a ready slot.
        check("drop.pre_ready", 32'(s_ready_o), 32'(slot != SYNC_PERIOD - 1));
        pll_locked_i = 1'b0;
        s_valid_i    = 1'b1;
        s_dat_i      = next_dat;
        step();
        push_exp(1'b1, IDLE_W, 1'b0, 1'b0);
        pop_cmp("drop");
        check("drop.s_ready", 32'(s_ready_o), 32'd0);
        step();
        push_exp(1'b1, IDLE_W, 1'b0, 1'b0);
        pop_cmp("drop_hold");
        pll_locked_i = 1'b1;

        // Relock: full bring-up again; the unconsumed word must come out first.
        bringup();
        repeat (12) link_cycle(1'b1);

        // Reset in the middle of LINK.
        rst = 1'b1;
        step();
        push_exp(1'b1, IDLE_W, 1'b0, 1'b0);
        pop_cmp("mid_rst");
        check("mid_rst.s_ready", 32'(s_ready_o), 32'd0);
        rst       = 1'b0;
        s_valid_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
